// File: rtl/recip_mult_norm.sv
// recip_mult_norm: iterative shift-add mantissa multiply with hidden-one normalization
// Ports: clk/rst (sync, active-high); i_in_valid/o_in_ready operand handshake;
//   i_a_mant, i_recip Q1.(W-1) operands; o_out_valid/i_out_ready result handshake;
//   o_out_mant Q1.(W-1) result, o_out_exp_adj exponent decrement flag, o_out_zero zero product.
// Optional: define RECIP_MULT_ROUND_EN for round half-up on the guard bit (default truncates).
module recip_mult_norm #(
  parameter int MANT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [MANT_WIDTH-1:0] i_a_mant,
  input  logic [MANT_WIDTH-1:0] i_recip,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [MANT_WIDTH-1:0] o_out_mant,
  output logic                  o_out_exp_adj,
  output logic                  o_out_zero
);
  localparam int W  = MANT_WIDTH;
  localparam int CW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;
  state_t         r_state;
  logic [2*W-1:0] r_a;
  logic [W-1:0]   r_b;
  logic [2*W-1:0] r_acc;
  logic [CW-1:0]  r_cnt;
  logic           r_valid;
  logic [W-1:0]   r_mant;
  logic           r_adj;
  logic           r_zero;
  logic           w_zero;
  logic           w_top;
  logic [W-1:0]   w_trunc;
  logic [W-1:0]   w_mant;
  logic           w_adj;
`ifdef RECIP_MULT_ROUND_EN
  logic           w_guard;
  logic [W:0]     w_rnd;
`endif
  // Product is below 2.0, so bit 2W-2 is the integer one; otherwise shift left by one.
  always_comb begin
    w_zero  = ~|r_acc;
    w_top   = r_acc[2*W-2];
    w_trunc = w_top ? r_acc[2*W-2 -: W] : r_acc[2*W-3 -: W];
`ifdef RECIP_MULT_ROUND_EN
    w_guard = w_top ? r_acc[W-2] : r_acc[W-3];
    w_rnd   = {1'b0, w_trunc} + {{W{1'b0}}, w_guard};
    // Carry out of an all-ones mantissa renormalizes to 1.0 and cancels the decrement.
    w_mant  = w_rnd[W] ? {1'b1, {(W-1){1'b0}}} : w_rnd[W-1:0];
    w_adj   = ~w_top & ~w_rnd[W];
`else
    w_mant  = w_trunc;
    w_adj   = ~w_top;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_mant  <= '0;
      r_adj   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_in_valid) begin
          r_a     <= {{W{1'b0}}, i_a_mant};
          r_b     <= i_recip;
          r_acc   <= '0;
          r_cnt   <= CW'(W);
          r_state <= MUL;
        end
        MUL: begin
          if (r_b[0]) r_acc <= r_acc + r_a;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= NORM;
        end
        NORM: begin
          r_mant  <= w_zero ? '0 : w_mant;
          r_adj   <= ~w_zero & w_adj;
          r_zero  <= w_zero;
          r_valid <= 1'b1;
          r_state <= DONE;
        end
        default: if (i_out_ready) begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
  assign o_in_ready    = (r_state == IDLE);
  assign o_out_valid   = r_valid;
  assign o_out_mant    = r_mant;
  assign o_out_exp_adj = r_adj;
  assign o_out_zero    = r_zero;
endmodule
